// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad, debounces per frame and shifts accepted keys into a 4-digit hex buffer.
module keypad_scanner #(
    parameter int SCAN_DIV = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic        gclk,
    input  logic        rst,
    input  logic [2:0]  keypadc,
    output logic [3:0]  keypadr,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] hexx
);
    logic [2:0]  c_s1, c_s2, closed;
    logic [7:0]  cnt;
    logic [1:0]  row, hits, row_n, hits_nx, col;
    logic [2:0]  sum;
    logic [3:0]  acc_code, acc_nx, row_code, f_code, st_code, dcnt, inc;
    logic [5:0]  res, prev;
    logic        sample, frame_end, f_multi, f_key, st_key, same_st, accept;
    logic [15:0] hex_nx;
    always_comb begin
        closed    = ~c_s2;
        sample    = cnt == 8'(SCAN_DIV - 1);
        frame_end = sample && row == 2'd3;
        row_n     = 2'(closed[0]) + 2'(closed[1]) + 2'(closed[2]);
        sum       = 3'(hits) + 3'(row_n);
        hits_nx   = sum >= 3'd2 ? 2'd2 : sum[1:0];
        col       = closed[0] ? 2'd0 : closed[1] ? 2'd1 : 2'd2;
        // bottom row carries the non-numeric keys: * = E, 0, # = F
        row_code  = row == 2'd3 ? (col == 2'd0 ? 4'hE : col == 2'd1 ? 4'h0 : 4'hF)
                                : 4'(row) * 4'd3 + 4'(col) + 4'd1;
        acc_nx    = (hits == 2'd0 && row_n == 2'd1) ? row_code : acc_code;
        f_multi   = hits_nx == 2'd2;
        f_key     = hits_nx == 2'd1;
        f_code    = f_key ? acc_nx : 4'h0;
        res       = {f_multi, f_key, f_code};
        same_st   = {f_key, f_code} == {st_key, st_code};
        inc       = res == prev ? dcnt + 4'd1 : 4'd1;
        accept    = !f_multi && !same_st && inc == 4'(DEBOUNCE);
        hex_nx    = f_code == 4'hE ? 16'h0000 :
                    f_code == 4'hF ? {4'h0, hexx[15:4]} : {hexx[11:0], f_code};
    end
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            c_s1      <= 3'b111;
            c_s2      <= 3'b111;
            cnt       <= '0;
            row       <= '0;
            keypadr   <= 4'b1110;
            hits      <= '0;
            acc_code  <= '0;
            dcnt      <= '0;
            prev      <= '0;
            st_key    <= 1'b0;
            st_code   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            hexx      <= '0;
        end else begin
            c_s1      <= keypadc;
            c_s2      <= c_s1;
            key_valid <= 1'b0;
            cnt       <= sample ? 8'd0 : cnt + 8'd1;
            if (sample) begin
                row      <= row + 2'd1;
                keypadr  <= {keypadr[2:0], keypadr[3]};
                hits     <= frame_end ? 2'd0 : hits_nx;
                acc_code <= frame_end ? 4'h0 : acc_nx;
            end
            if (frame_end) begin
                prev <= res;
                dcnt <= (f_multi || same_st || accept) ? 4'd0 : inc;
                if (accept) begin
                    st_key   <= f_key;
                    st_code  <= f_code;
                    key_held <= f_key;
                    if (f_key) begin
                        key_code  <= f_code;
                        key_valid <= 1'b1;
                        hexx      <= hex_nx;
                    end
                end
            end
        end
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4-row x 3-column matrix keypad, debounces it and decodes one key at a time.
- Each accepted keypress is shifted into a 4-digit hex buffer.
- The buffer drives the hexx input of the 4-digit 7-segment display driver, so this block is the stage directly upstream of the display.
- Runs on the same divided scan clock domain as the display. The clock port is gclk.

Parameters:
- SCAN_DIV, 8: clock cycles each row is driven before its columns are sampled. Legal range 4..255.
- DEBOUNCE, 3: consecutive identical scan frames required to accept a change. Legal range 1..15.

Ports:
- gclk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- keypadc  input  3  column sense lines, active-low (pulled up externally; 0 = key closed in the driven row)
- keypadr  output  4  row drive, active-low one-hot (exactly one bit 0 at all times)
- key_code  output  4  code of the most recently accepted key
- key_valid  output  1  one-cycle pulse when a new press is accepted
- key_held  output  1  high while a debounced key is held
- hexx  output  16  digit buffer, digit0 = hexx[3:0] (rightmost)

Behaviour:
- Reset (async, active-high), all values applied immediately:
  - keypadr=4'b1110, row index=0, slot counter=0, frame accumulator cleared.
  - Debounce counter=0, stable state=NONE.
  - key_code=0, key_valid=0, key_held=0, hexx=16'h0000.
  - Reset asserted mid-scan or mid-debounce aborts everything; scanning restarts at row 0 on the first gclk edge after release.
- Input sync: keypadc passes through 2 flops before any use. This 2-cycle delay is why SCAN_DIV >= 4.
- Scan:
  - The slot counter counts 0..SCAN_DIV-1 per row.
  - On the last cycle of a slot (count == SCAN_DIV-1), sample the synchronized columns for the current row, then advance the row 0->1->2->3->0 and rotate keypadr accordingly.
  - One frame = 4*SCAN_DIV cycles.
- Key map (row, col -> code):
  - r0: 1,2,3
  - r1: 4,5,6
  - r2: 7,8,9
  - r3: *=4'hE, 0=4'h0, #=4'hF
- Frame result, evaluated at the end of the row-3 sample:
  - NONE: no closures.
  - KEY(code): exactly one closure.
  - MULTI: two or more closures.
- Debounce, once per frame:
  - MULTI: reset the debounce counter; stable state unchanged; no event.
  - Result == stable state: reset the debounce counter.
  - Otherwise, if result == the previous frame's result, increment the counter; else set it to 1.
  - When the counter reaches DEBOUNCE, stable state := result and the counter resets.
  - With DEBOUNCE=1, a change is accepted on the first frame.
- Events on a stable-state change, all in the cycle after the frame end:
  - To KEY(k), from NONE or from a different key: key_code:=k, key_held:=1, key_valid=1 for exactly one cycle, then the buffer action below.
  - To NONE: key_held:=0; no pulse; key_code keeps its value.
  - Holding a key produces no repeats.
- Buffer actions, applied in the same cycle key_valid is high:
  - Digit 0-9: hexx := {hexx[11:0], k}. The oldest digit is discarded (wrap-out at the left).
  - * (E): hexx := 16'h0000.
  - # (F): hexx := {4'h0, hexx[15:4]} (backspace).
- Outputs are registered only; no combinational path from keypadc to any output.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, so frame = 16 cycles):
1. Reset, then idle for 3 frames -> keypadr cycles 1110,1101,1011,0111 changing every 4 cycles; hexx=0000; key_valid never asserts.
2. Hold row1/col2 ('6') steady for 3 frames, then release for 3 frames -> exactly one key_valid pulse at the end of frame 2, key_code=6, hexx=0006; key_held=1 until 2 NONE frames, then 0.
3. Press and release in sequence '1','2','3','4','5' -> hexx=2345 (the '1' is shifted out); exactly 5 key_valid pulses.
4. From hexx=2345: press '#' -> hexx=0234. Then press '*' -> hexx=0000, key_code=E.
5. Hold '5' and '8' together for 4 frames -> no pulse, stable state unchanged. Then bounce '9' one frame on / one off / two on -> a single accepted press, key_code=9, after the second consecutive frame.
6. Assert rst mid-frame while '7' is held with 1 frame counted -> all outputs return to reset values at once. After release with '7' still held, the press is accepted 2 full frames later and hexx=0007.
